sample_accumulator: RTL and testbench
=====================================

Name: sample_accumulator

Overview:
- Sequential stage directly downstream of adder_nbit. Accepts a fixed-length burst of BIT_WIDTH-bit samples over a valid/ready handshake.
- Folds each sample into a running accumulator register through one adder_nbit instance.
- Reports the final sum, a one-cycle result strobe and a sticky overflow flag.
- Serves as the datapath controller for multi-operand sums in the lab designs.

Parameters:
- BIT_WIDTH, 4, width of samples and accumulator (>=2).
- NUM_SAMPLES, 4, samples accepted per run (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- start  input  1  begin a new run; sampled only in IDLE.
- data_in  input  BIT_WIDTH  sample value.
- data_valid  input  1  data_in is valid this cycle.
- data_ready  output  1  block accepts a sample this cycle.
- sum_out  output  BIT_WIDTH  accumulator value, registered.
- sum_valid  output  1  one-cycle strobe: sum_out is final.
- overflow  output  1  sticky: any carry-out during current/last run.
- busy  output  1  high in ACCUM and DONE.

Behaviour:
- Interface: one clock, clk; reset n_rst is asynchronous and active-low.
- Reset values:
  - state=IDLE.
  - sum_out=0, overflow=0, sum_valid=0, data_ready=0, busy=0.
  - Internal sample count=0.
- All outputs are registered or decoded purely from state. No combinational path from inputs to outputs.
- IDLE:
  - data_ready=0.
  - On start=1: next edge clears accumulator to 0, clears overflow and count, and goes to ACCUM.
- ACCUM:
  - data_ready=1.
  - A transfer occurs on any edge where data_valid=1 and data_ready=1.
  - On each transfer:
    - accumulator <= adder_nbit.sum(a=accumulator, b=data_in, carry_in=0).
    - overflow <= overflow | adder_nbit.overflow.
    - count <= count+1.
  - data_valid=0 cycles are stalls: no state change.
  - The transfer with count==NUM_SAMPLES-1 moves to DONE.
- DONE:
  - sum_valid=1 for exactly one cycle, data_ready=0, then return to IDLE.
  - Latency: sum_valid is high in the cycle immediately after the edge that accepted the final sample.
- sum_out and overflow hold their values in IDLE until the next accepted start.
- start is ignored in ACCUM and DONE. A start held high through DONE is honoured in the first IDLE cycle.
- Arithmetic is unsigned, modulo 2^BIT_WIDTH (see optional feature).
- Count register width is $clog2(NUM_SAMPLES+1). NUM_SAMPLES=1 gives IDLE->ACCUM->DONE after one transfer.
- Reset asserted mid-run aborts immediately to the reset values. Partial sums are discarded.
- Simulation checks:
  - On every transfer, data_in must contain no X/Z; otherwise $error.
  - Two cycles after each transfer, an immediate assertion confirms sum_out == (previous + data_in) mod 2^BIT_WIDTH.

Optional Feature:
- Macro: SAMPLE_ACCUMULATOR_SATURATE_EN.
- Defined: any transfer producing a carry-out loads the accumulator with all ones. Subsequent transfers in the same run keep it at all ones. overflow still sets.
- Undefined: the accumulator wraps modulo 2^BIT_WIDTH. overflow is the only indication.

Decomposition:
- Shared package sample_accumulator_pkg holds:
  - State typedef: enum logic [1:0] {IDLE, ACCUM, DONE}.
  - Default width constants.
- Sub-module: reuse adder_nbit unchanged as the single adder instance, with BIT_WIDTH passed through.
- The FSM and the count/accumulator registers stay in one module.

Test Plan:
All scenarios use BIT_WIDTH=4, NUM_SAMPLES=4.
- Reset: n_rst=0 mid-ACCUM after two samples -> all outputs 0 and state IDLE asynchronously. No sum_valid after release.
- Basic run: start, then samples 1,2,3,4 with valid every cycle -> sum_out=10, overflow=0, sum_valid high exactly one cycle after the 4th transfer, busy low the following cycle.
- Stalls: samples 5,0,2,1 with data_valid low 3 cycles between each -> sum_out=8, sum_valid timing relative to the last transfer unchanged.
- Overflow wrap (macro undefined): samples 8,8,1,0 -> sum_out=1, overflow=1. The next run 1,1,1,1 clears it -> sum_out=4, overflow=0.
- Saturate (SAMPLE_ACCUMULATOR_SATURATE_EN defined): samples 8,8,1,0 -> sum_out=15, overflow=1.
- start pulsed during ACCUM and DONE -> ignored, result unaffected. start held through DONE -> new run begins the first IDLE cycle with sum_out cleared to 0.

Source files
------------

// File: rtl/sample_accumulator_pkg.sv
// Shared types and default sizing for the sample_accumulator block.
// The state encoding lives here so the RTL and any block above it agree on it.
package sample_accumulator_pkg;

    localparam int DEF_BIT_WIDTH   = 4;
    localparam int DEF_NUM_SAMPLES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/adder_nbit.sv
// Unsigned ripple adder: sum = a + b + carry_in, with the carry-out reported on overflow.
module adder_nbit #(
    parameter int BIT_WIDTH = 4
) (
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 carry_in,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 overflow
);

    assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {{BIT_WIDTH{1'b0}}, carry_in};

endmodule

// File: rtl/sample_accumulator.sv
// Accumulates a fixed-length burst of samples through one adder_nbit; reports sum, strobe, sticky overflow.
// Optional saturation on carry-out is enabled with macro SAMPLE_ACCUMULATOR_SATURATE_EN.
module sample_accumulator
    import sample_accumulator_pkg::*;
#(
    parameter int BIT_WIDTH   = DEF_BIT_WIDTH,
    parameter int NUM_SAMPLES = DEF_NUM_SAMPLES
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic [BIT_WIDTH-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic [BIT_WIDTH-1:0] sum_out,
    output logic                 sum_valid,
    output logic                 overflow,
    output logic                 busy
);

    localparam int                CNT_W    = $clog2(NUM_SAMPLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [BIT_WIDTH-1:0] r_acc;
    logic [BIT_WIDTH-1:0] w_add_sum;
    logic [BIT_WIDTH-1:0] w_acc_nxt;
    logic                 w_add_ovf;
    logic                 r_ovf;
    logic [CNT_W-1:0]     r_cnt;
    logic                 w_xfer;
    logic                 w_clear;

    adder_nbit #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_adder (
        .a        (r_acc),
        .b        (data_in),
        .carry_in (1'b0),
        .sum      (w_add_sum),
        .overflow (w_add_ovf)
    );

    assign w_xfer  = (r_state == ACCUM) && data_valid;
    assign w_clear = (r_state == IDLE) && start;

`ifdef SAMPLE_ACCUMULATOR_SATURATE_EN
    // Once at all ones, any nonzero sample carries again, so the value sticks for the run.
    assign w_acc_nxt = w_add_ovf ? {BIT_WIDTH{1'b1}} : w_add_sum;
`else
    assign w_acc_nxt = w_add_sum;
`endif

    always_comb begin
        // NOTE: every output of this block is given a default first so no path can infer a latch.
        w_state_nxt = r_state;
        data_ready  = 1'b0;
        sum_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = ACCUM;
            end
            ACCUM: begin
                data_ready = 1'b1;
                busy       = 1'b1;
                if (w_xfer && (r_cnt == LAST_CNT)) w_state_nxt = DONE;
            end
            DONE: begin
                sum_valid   = 1'b1;
                busy        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (!n_rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clear) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
                r_cnt <= '0;
            end else if (w_xfer) begin
                r_acc <= w_acc_nxt;
                r_ovf <= r_ovf | w_add_ovf;
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign sum_out  = r_acc;
    assign overflow = r_ovf;

`ifndef SYNTHESIS
    // Independent re-computation of each transfer, compared two cycles later.
    logic [BIT_WIDTH-1:0] w_chk_exp;
`ifdef SAMPLE_ACCUMULATOR_SATURATE_EN
    logic [BIT_WIDTH:0]   w_chk_sum;
    assign w_chk_sum = {1'b0, r_acc} + {1'b0, data_in};
    assign w_chk_exp = w_chk_sum[BIT_WIDTH] ? {BIT_WIDTH{1'b1}} : w_chk_sum[BIT_WIDTH-1:0];
`else
    assign w_chk_exp = r_acc + data_in;
`endif

    logic                 r_chk1_vld;
    logic                 r_chk2_vld;
    logic [BIT_WIDTH-1:0] r_chk1_exp;
    logic [BIT_WIDTH-1:0] r_chk2_exp;
    logic [BIT_WIDTH-1:0] r_chk2_obs;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_chk1_vld <= 1'b0;
            r_chk2_vld <= 1'b0;
            r_chk1_exp <= '0;
            r_chk2_exp <= '0;
            r_chk2_obs <= '0;
        end else begin
            if (w_xfer && $isunknown(data_in))
                $error("sample_accumulator: data_in has X/Z on a transfer");
            r_chk1_vld <= w_xfer;
            r_chk1_exp <= w_chk_exp;
            r_chk2_vld <= r_chk1_vld;
            r_chk2_exp <= r_chk1_exp;
            r_chk2_obs <= r_acc;
            if (r_chk2_vld)
                assert (r_chk2_obs == r_chk2_exp)
                else $error("sample_accumulator: sum_out %0d, expected %0d", r_chk2_obs, r_chk2_exp);
        end
    end
`endif

endmodule

// File: tb/tb_sample_accumulator.sv
// Self-checking bench for sample_accumulator (BIT_WIDTH=4, NUM_SAMPLES=4) using a result scoreboard.
// Build with SAMPLE_ACCUMULATOR_SATURATE_EN defined to exercise the saturating variant.
module tb_sample_accumulator;

    localparam int W = 4;
    localparam int N = 4;

`ifdef SAMPLE_ACCUMULATOR_SATURATE_EN
    localparam logic [W-1:0] WRAP_EXP = 4'd15;
`else
    localparam logic [W-1:0] WRAP_EXP = 4'd1;
`endif

    typedef struct packed {
        logic [W-1:0] sum;
        logic         ovf;
    } res_t;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         start;
    logic [W-1:0] data_in;
    logic         data_valid;
    logic         data_ready;
    logic [W-1:0] sum_out;
    logic         sum_valid;
    logic         overflow;
    logic         busy;

    int           n_chk = 0;
    int           n_bad = 0;
    int           n_sv  = 0;
    res_t         sb_q[$];
    logic [W-1:0] smp [N];

    sample_accumulator #(
        .BIT_WIDTH   (W),
        .NUM_SAMPLES (N)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .sum_out    (sum_out),
        .sum_valid  (sum_valid),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model for one run over smp[].
    function automatic res_t model_run();
        res_t       r;
        logic [W:0] t;
        r.sum = '0;
        r.ovf = 1'b0;
        for (int i = 0; i < N; i++) begin
            t     = {1'b0, r.sum} + {1'b0, smp[i]};
            r.ovf = r.ovf | t[W];
`ifdef SAMPLE_ACCUMULATOR_SATURATE_EN
            r.sum = t[W] ? {W{1'b1}} : t[W-1:0];
`else
            r.sum = t[W-1:0];
`endif
        end
        return r;
    endfunction

    // Scoreboard side: every result strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (sum_valid) begin
            res_t r;
            n_sv++;
            chk("sb_pending", (sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                r = sb_q.pop_front();
                chk("sb_sum", sum_out, r.sum);
                chk("sb_ovf", overflow, r.ovf);
            end
        end
    end

    // Called at a negedge while IDLE; leaves the DUT in ACCUM at the next negedge.
    task automatic do_start(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_st_busy"}, busy, 1);
        chk({tag, "_st_rdy"}, data_ready, 1);
        chk({tag, "_st_sum"}, sum_out, 0);
        chk({tag, "_st_ovf"}, overflow, 0);
    endtask

    // end_mode: 0 = quiet, 1 = start pulsed in DONE, 2 = start held through DONE into a new run.
    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                       input logic [W-1:0] d, input int stall, input bit poke_start,
                       input int end_mode, input logic [W-1:0] exp_sum, input logic exp_ovf,
                       input string tag);
        smp = '{a, b, c, d};
        for (int i = 0; i < N; i++) begin
            for (int s = 0; s < stall; s++) begin
                data_valid = 1'b0;
                start      = poke_start && (s == 0);
                @(negedge clk);
            end
            start      = 1'b0;
            data_valid = 1'b1;
            data_in    = smp[i];
            if (i == N - 1) sb_q.push_back(model_run());
            chk({tag, "_rdy"}, data_ready, 1);
            @(negedge clk);
            data_valid = 1'b0;
            if (i < N - 1) chk({tag, "_no_early_sv"}, sum_valid, 0);
        end
        chk({tag, "_sv_lat"}, sum_valid, 1);
        chk({tag, "_done_busy"}, busy, 1);
        chk({tag, "_done_rdy"}, data_ready, 0);
        chk({tag, "_sum"}, sum_out, exp_sum);
        chk({tag, "_ovf"}, overflow, exp_ovf);
        start = (end_mode != 0);
        @(negedge clk);
        chk({tag, "_sv_drop"}, sum_valid, 0);
        chk({tag, "_busy_low"}, busy, 0);
        chk({tag, "_hold_sum"}, sum_out, exp_sum);
        chk({tag, "_hold_ovf"}, overflow, exp_ovf);
        if (end_mode == 1) begin
            start = 1'b0;
            @(negedge clk);
            chk({tag, "_done_start_ign"}, busy, 0);
        end else if (end_mode == 2) begin
            @(negedge clk);
            start = 1'b0;
            chk({tag, "_held_busy"}, busy, 1);
            chk({tag, "_held_sum"}, sum_out, 0);
            chk({tag, "_held_ovf"}, overflow, 0);
        end
    endtask

    initial begin
        int sv_before;
        n_rst      = 1'b1;
        start      = 1'b0;
        data_valid = 1'b0;
        data_in    = '0;
        #2 n_rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_sum", sum_out, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_sv", sum_valid, 0);
        chk("rst_rdy", data_ready, 0);
        chk("rst_busy", busy, 0);
        n_rst = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        do_start("basic");
        run(4'd1, 4'd2, 4'd3, 4'd4, 0, 1'b0, 0, 4'd10, 1'b0, "basic");

        do_start("stall");
        run(4'd5, 4'd0, 4'd2, 4'd1, 3, 1'b1, 1, 4'd8, 1'b0, "stall");

        do_start("wrap");
        run(4'd8, 4'd8, 4'd1, 4'd0, 0, 1'b0, 2, WRAP_EXP, 1'b1, "wrap");
        run(4'd1, 4'd1, 4'd1, 4'd1, 0, 1'b0, 0, 4'd4, 1'b0, "clear");

        // Abort mid-run: two samples in, then an asynchronous reset between clock edges.
        do_start("abort");
        data_valid = 1'b1;
        data_in    = 4'd3;
        @(negedge clk);
        data_in = 4'd5;
        @(negedge clk);
        data_valid = 1'b0;
        chk("abort_partial", sum_out, 8);
        #2 n_rst = 1'b0;
        #1;
        chk("abort_sum", sum_out, 0);
        chk("abort_ovf", overflow, 0);
        chk("abort_sv", sum_valid, 0);
        chk("abort_rdy", data_ready, 0);
        chk("abort_busy", busy, 0);
        @(negedge clk);
        n_rst     = 1'b1;
        sv_before = n_sv;
        repeat (4) @(negedge clk);
        chk("abort_no_sv", n_sv, sv_before);
        chk("abort_idle", busy, 0);

        do_start("post");
        run(4'd2, 4'd3, 4'd4, 4'd5, 1, 1'b0, 0, 4'd14, 1'b0, "post");

        repeat (2) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
